// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, RV64I opcodes and the
// operation bundle handed from issue to execute.
package alu_pkg;

    localparam int XLEN   = 64;
    localparam int ILEN   = 32;
    localparam int CTRL_W = 5;

    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD   = 5'b00000,
        ALU_SUB   = 5'b00001,
        ALU_AND   = 5'b00010,
        ALU_OR    = 5'b00011,
        ALU_XOR   = 5'b00100,
        ALU_SLL   = 5'b00101,
        ALU_SLT   = 5'b00110,
        ALU_SLTU  = 5'b00111,
        ALU_SRL   = 5'b01000,
        ALU_SRA   = 5'b01001,
        ALU_SLLI  = 5'b01010,
        ALU_SRLI  = 5'b01011,
        ALU_SRAI  = 5'b01100,
        ALU_ADDW  = 5'b01101,
        ALU_SUBW  = 5'b01110,
        ALU_SLLW  = 5'b01111,
        ALU_SRLW  = 5'b10000,
        ALU_SRAW  = 5'b10001,
        ALU_ADDIW = 5'b10010
    } t_alu_op;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    typedef struct packed {
        t_alu_op         alu_control;
        logic [XLEN-1:0] src_1;
        logic [XLEN-1:0] src_2;
        logic            illegal;
    } t_issue_payload;

endpackage

// File: rtl/alu_issue_stage_decoder.sv
// Combinational decode of one instruction into ALU control code
// and operand selection.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [ILEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    output t_issue_payload  o_payload
);

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            b30;
    t_alu_op         ctl;
    logic [XLEN-1:0] s1;
    logic [XLEN-1:0] s2;
    logic            ill;
    logic            unused_instr;

    assign opc = i_instr[6:0];
    assign f3  = i_instr[14:12];
    assign b30 = i_instr[30];
    assign unused_instr = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

    always_comb begin
        ctl = ALU_ADD;
        s1  = i_rs1;
        s2  = i_rs2;
        ill = 1'b0;
        case (opc)
            OPC_OP: begin
                case (f3)
                    3'b000:  ctl = b30 ? ALU_SUB : ALU_ADD;
                    3'b001:  ctl = ALU_SLL;
                    3'b010:  ctl = ALU_SLT;
                    3'b011:  ctl = ALU_SLTU;
                    3'b100:  ctl = ALU_XOR;
                    3'b101:  ctl = b30 ? ALU_SRA : ALU_SRL;
                    3'b110:  ctl = ALU_OR;
                    default: ctl = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                s2 = i_imm;
                case (f3)
                    3'b000:  ctl = ALU_ADD;
                    3'b001:  ctl = ALU_SLLI;
                    3'b010:  ctl = ALU_SLT;
                    3'b011:  ctl = ALU_SLTU;
                    3'b100:  ctl = ALU_XOR;
                    3'b101:  ctl = b30 ? ALU_SRAI : ALU_SRLI;
                    3'b110:  ctl = ALU_OR;
                    default: ctl = ALU_AND;
                endcase
            end
            OPC_OP_32: begin
                case (f3)
                    3'b000:  ctl = b30 ? ALU_SUBW : ALU_ADDW;
                    3'b001:  ctl = ALU_SLLW;
                    3'b101:  ctl = b30 ? ALU_SRAW : ALU_SRLW;
                    default: ill = 1'b1;
                endcase
            end
            OPC_OP_IMM_32: begin
                s2 = i_imm;
                case (f3)
                    3'b000:  ctl = ALU_ADDIW;
                    3'b001:  ctl = ALU_SLLW;
                    3'b101:  ctl = b30 ? ALU_SRAW : ALU_SRLW;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                s2 = i_imm;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000, 3'b001: ctl = ALU_SUB;
                    3'b100, 3'b101: ctl = ALU_SLT;
                    3'b110, 3'b111: ctl = ALU_SLTU;
                    default:        ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                s1 = '0;
                s2 = i_imm;
            end
            OPC_AUIPC, OPC_JAL: begin
                s1 = i_pc;
                s2 = i_imm;
            end
            default: ill = 1'b1;
        endcase
        // Undecodable ops still travel as a harmless rs1 + rs2 add.
        if (ill) begin
            ctl = ALU_ADD;
            s1  = i_rs1;
            s2  = i_rs2;
        end
    end

    assign o_payload = '{alu_control: ctl, src_1: s1, src_2: s2, illegal: ill};

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus a registered 2-entry skid buffer
// towards execute, with flush.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = XLEN,
    parameter int INSTR_WIDTH   = ILEN,
    parameter int CONTROL_WIDTH = CTRL_W
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [INSTR_WIDTH-1:0]   i_instr,
    input  logic [DATA_WIDTH-1:0]    i_pc,
    input  logic [DATA_WIDTH-1:0]    i_rs1_data,
    input  logic [DATA_WIDTH-1:0]    i_rs2_data,
    input  logic [DATA_WIDTH-1:0]    i_imm,
    input  logic                     i_flush,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [CONTROL_WIDTH-1:0] o_alu_control,
    output logic [DATA_WIDTH-1:0]    o_src_1,
    output logic [DATA_WIDTH-1:0]    o_src_2,
    output logic                     o_illegal_instr
);

    t_issue_payload dec;
    t_issue_payload main_q, main_d;
    t_issue_payload skid_q, skid_d;
    logic           main_valid_q, main_valid_d;
    logic           skid_valid_q, skid_valid_d;
    logic           accept;
    logic           consume;

    alu_op_decoder u_dec (
        .i_instr   (i_instr),
        .i_pc      (i_pc),
        .i_rs1     (i_rs1_data),
        .i_rs2     (i_rs2_data),
        .i_imm     (i_imm),
        .o_payload (dec)
    );

    assign o_ready = ~skid_valid_q;
    assign accept  = i_valid & o_ready;
    assign consume = main_valid_q & i_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (i_flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || consume) begin
            // Skid only fills while main is held, so it drains first.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = dec;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = dec;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign o_valid         = main_valid_q;
    assign o_alu_control   = main_q.alu_control;
    assign o_src_1         = main_q.src_1;
    assign o_src_2         = main_q.src_2;
    assign o_illegal_instr = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic
// checked against a mnemonic-level decoder and an in-order queue.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        arstn;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [63:0] i_pc;
    logic [63:0] i_rs1_data;
    logic [63:0] i_rs2_data;
    logic [63:0] i_imm;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [4:0]  o_alu_control;
    logic [63:0] o_src_1;
    logic [63:0] o_src_2;
    logic        o_illegal_instr;

    alu_issue_stage dut (
        .clk             (clk),
        .arstn           (arstn),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_instr         (i_instr),
        .i_pc            (i_pc),
        .i_rs1_data      (i_rs1_data),
        .i_rs2_data      (i_rs2_data),
        .i_imm           (i_imm),
        .i_flush         (i_flush),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_alu_control   (o_alu_control),
        .o_src_1         (o_src_1),
        .o_src_2         (o_src_2),
        .o_illegal_instr (o_illegal_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ctl;
        logic [63:0] s1;
        logic [63:0] s2;
        logic        ill;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;

    // Mnemonics listed in control-code order.
    string codes[19] = '{"add", "sub", "and", "or", "xor", "sll", "slt",
                         "sltu", "srl", "sra", "slli", "srli", "srai",
                         "addw", "subw", "sllw", "srlw", "sraw", "addiw"};
    string op_names[8]  = '{"add", "sll", "slt", "sltu",
                            "xor", "srl", "or", "and"};
    string imm_names[8] = '{"add", "slli", "slt", "sltu",
                            "xor", "srli", "or", "and"};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic string mnem(input logic [31:0] ins);
        logic [2:0] f;
        logic       alt;
        f   = ins[14:12];
        alt = ins[30];
        case (ins[6:0])
            7'b0110011: begin
                if (f == 3'd0 && alt) return "sub";
                if (f == 3'd5 && alt) return "sra";
                return op_names[f];
            end
            7'b0010011: begin
                if (f == 3'd5 && alt) return "srai";
                return imm_names[f];
            end
            7'b0111011, 7'b0011011: begin
                if (f == 3'd0) begin
                    if (ins[6:0] == 7'b0011011) return "addiw";
                    return alt ? "subw" : "addw";
                end
                if (f == 3'd1) return "sllw";
                if (f == 3'd5) return alt ? "sraw" : "srlw";
                return "illegal";
            end
            7'b1100011: begin
                if (f == 3'd2 || f == 3'd3) return "illegal";
                if (f < 3'd4) return "sub";
                if (f < 3'd6) return "slt";
                return "sltu";
            end
            7'b0000011, 7'b0100011, 7'b1100111,
            7'b0110111, 7'b0010111, 7'b1101111: return "add";
            default: return "illegal";
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins,
                                        input logic [63:0] pc, a, b, im);
        exp_t  e;
        string m;
        m     = mnem(ins);
        e.ill = (m == "illegal");
        e.ctl = 5'd0;
        for (int k = 0; k < 19; k++)
            if (codes[k] == m) e.ctl = 5'(k);
        e.s1 = a;
        e.s2 = b;
        if (!e.ill) begin
            if (ins[6:0] == 7'b0110111) e.s1 = 64'd0;
            if (ins[6:0] == 7'b0010111 || ins[6:0] == 7'b1101111) e.s1 = pc;
            if (!(ins[6:0] inside {7'b0110011, 7'b0111011, 7'b1100011}))
                e.s2 = im;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  op;
        logic [6:0]  known[11] = '{7'b0110011, 7'b0010011, 7'b0111011,
                                   7'b0011011, 7'b0000011, 7'b0100011,
                                   7'b1100111, 7'b1100011, 7'b0110111,
                                   7'b0010111, 7'b1101111};
        ins = $urandom;
        if ($urandom_range(0, 9) == 0) begin
            op = 7'($urandom);
        end else begin
            op = known[$urandom_range(0, 10)];
        end
        ins[6:0] = op;
        return ins;
    endfunction

    task automatic check_model();
        chk("o_valid", 64'(o_valid), 64'(q.size() > 0));
        chk("o_ready", 64'(o_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("alu_control", 64'(o_alu_control), 64'(q[0].ctl));
            chk("src_1", o_src_1, q[0].s1);
            chk("src_2", o_src_2, q[0].s2);
            chk("illegal", 64'(o_illegal_instr), 64'(q[0].ill));
        end
    endtask

    // Called at a negedge; drives one cycle and checks the result.
    task automatic step(input logic v, input logic [31:0] ins,
                        input logic [63:0] pc, a, b, im,
                        input logic rdy, fl, output bit acc);
        i_valid    = v;
        i_instr    = ins;
        i_pc       = pc;
        i_rs1_data = a;
        i_rs2_data = b;
        i_imm      = im;
        i_ready    = rdy;
        i_flush    = fl;
        acc = v && (q.size() < 2) && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(ins, pc, a, b, im));
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic rstep(input logic v, input logic rdy, input logic fl,
                         output bit acc);
        step(v, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, rdy, fl, acc);
    endtask

    task automatic drain();
        bit acc;
        for (int n = 0; n < 4 && q.size() > 0; n++) rstep(1'b0, 1'b1, 1'b0, acc);
        chk("drain_empty", 64'(o_valid), 64'd0);
    endtask

    logic [31:0] bp_ops[4];
    logic [63:0] ra, rb;
    bit          acc;
    int          idx;
    int          cyc;

    initial begin
        arstn = 1'b0;
        i_valid = 1'b0; i_instr = '0; i_pc = '0; i_rs1_data = '0;
        i_rs2_data = '0; i_imm = '0; i_flush = 1'b0; i_ready = 1'b0;
        #12;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_ctl", 64'(o_alu_control), 64'd0);
        chk("rst_src_1", o_src_1, 64'd0);
        chk("rst_src_2", o_src_2, 64'd0);
        chk("rst_ill", 64'(o_illegal_instr), 64'd0);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);

        step(1'b1, 32'h40B50533, 64'h80, 64'd10, 64'd3, 64'h55, 1'b1, 1'b0, acc);
        chk("sub_valid", 64'(o_valid), 64'd1);
        chk("sub_ctl", 64'(o_alu_control), 64'b00001);
        chk("sub_src_1", o_src_1, 64'd10);
        chk("sub_src_2", o_src_2, 64'd3);

        step(1'b1, 32'h00002517, 64'h1000, 64'd7, 64'd9, 64'h2000, 1'b1, 1'b0, acc);
        chk("auipc_ctl", 64'(o_alu_control), 64'd0);
        chk("auipc_src_1", o_src_1, 64'h1000);
        chk("auipc_src_2", o_src_2, 64'h2000);

        step(1'b1, 32'h40355513, 64'h84, 64'd5, 64'd6, 64'd3, 1'b1, 1'b0, acc);
        chk("srai_ctl", 64'(o_alu_control), 64'b01100);
        chk("srai_src_2", o_src_2, 64'd3);
        drain();

        bp_ops = '{32'h00B50533, 32'h40B50533, 32'h00B56533, 32'h00B57533};
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 20) begin
            step(1'b1, bp_ops[idx], 64'(cyc), 64'(100 + idx), 64'(idx), 64'd0,
                 cyc >= 3, 1'b0, acc);
            if (cyc == 1) chk("bp_ready_low", 64'(o_ready), 64'd0);
            if (acc) idx++;
            cyc++;
        end
        chk("bp_all_accepted", 64'(idx), 64'd4);
        drain();

        rstep(1'b1, 1'b0, 1'b0, acc);
        rstep(1'b1, 1'b0, 1'b0, acc);
        chk("fl_full", 64'(o_ready), 64'd0);
        rstep(1'b1, 1'b0, 1'b1, acc);
        chk("fl_valid", 64'(o_valid), 64'd0);
        chk("fl_ready", 64'(o_ready), 64'd1);
        rstep(1'b0, 1'b1, 1'b0, acc);
        chk("fl_no_ghost", 64'(o_valid), 64'd0);

        ra = 64'h1111_2222_3333_4444;
        rb = 64'h5555_6666_7777_8888;
        step(1'b1, 32'h0020A1BB, 64'h90, ra, rb, 64'h99, 1'b1, 1'b0, acc);
        chk("ill32_flag", 64'(o_illegal_instr), 64'd1);
        chk("ill32_ctl", 64'(o_alu_control), 64'd0);
        chk("ill32_src_1", o_src_1, ra);
        chk("ill32_src_2", o_src_2, rb);
        step(1'b1, 32'h0020B063, 64'h94, rb, ra, 64'h77, 1'b1, 1'b0, acc);
        chk("illbr_flag", 64'(o_illegal_instr), 64'd1);
        chk("illbr_ctl", 64'(o_alu_control), 64'd0);
        chk("illbr_src_1", o_src_1, rb);
        chk("illbr_src_2", o_src_2, ra);
        drain();

        rstep(1'b1, 1'b0, 1'b0, acc);
        rstep(1'b1, 1'b0, 1'b0, acc);
        i_valid = 1'b0;
        #2 arstn = 1'b0;
        q.delete();
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_ready", 64'(o_ready), 64'd1);
        chk("arst_ctl", 64'(o_alu_control), 64'd0);
        chk("arst_src_1", o_src_1, 64'd0);
        chk("arst_src_2", o_src_2, 64'd0);
        #1 arstn = 1'b1;
        @(negedge clk);
        check_model();

        for (int n = 0; n < 2000; n++) begin
            rstep($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 3, acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue stage feeding the RV64I ALU (the producer end of the ALU control/operand interface).
- Decodes a 32-bit instruction into the 5-bit ALU control code and selects both operands: register, PC, zero or immediate.
- Presents the result to the execute stage through a registered valid/ready interface with a 2-entry skid buffer, so throughput stays at one operation per cycle under backpressure.
- Supports flush.

Parameters:
- DATA_WIDTH, 64, operand/PC width
- INSTR_WIDTH, 32, instruction width
- CONTROL_WIDTH, 5, ALU control code width

Ports:
- clk  in  1  clock, rising edge
- arstn  in  1  asynchronous active-low reset
- i_valid  in  1  upstream has an instruction
- o_ready  out  1  stage can accept this cycle
- i_instr  in  32  instruction word
- i_pc  in  64  instruction PC
- i_rs1_data  in  64  rs1 register value
- i_rs2_data  in  64  rs2 register value
- i_imm  in  64  sign-extended immediate from the immediate generator
- i_flush  in  1  kill all held and incoming operations
- o_valid  out  1  operation available to the ALU
- i_ready  in  1  ALU/execute accepts this cycle
- o_alu_control  out  5  ALU control code
- o_src_1  out  64  ALU operand 1
- o_src_2  out  64  ALU operand 2
- o_illegal_instr  out  1  opcode/funct combination not ALU-decodable

Behaviour:
- Reset (arstn low, async): both buffer entries invalid; o_valid=0; o_ready=1; o_alu_control=ADD (5'b00000); o_src_1=0; o_src_2=0; o_illegal_instr=0.
- Handshake:
  - Input transfer when i_valid&o_ready.
  - Output transfer when o_valid&i_ready.
  - o_ready is a register output: 1 when the skid entry is empty.
  - o_valid = main entry valid.
  - Outputs come only from the main entry register, never combinationally from inputs.
- Latency: an accepted instruction appears at the outputs the next cycle when the main entry is empty or draining.
- Buffer rules:
  - Accept while the main entry is empty or being consumed → write to main.
  - Accept while main is held (o_valid&!i_ready) → write to skid; o_ready drops the next cycle.
  - Consume with skid full → skid moves to main; o_ready returns to 1 the next cycle.
  - Simultaneous accept and consume with skid empty → the new entry replaces main, no bubble.
  - Payload is held stable while o_valid&!i_ready.
- Flush: i_flush has priority over everything. Both entries are invalidated the next edge, any same-cycle input is dropped, and o_ready=1 the next cycle. Payload registers may keep stale values.
- Decode (opcode i_instr[6:0], f3 = i_instr[14:12], b30 = i_instr[30]):
  - OP 0110011, src1=rs1, src2=rs2:
    - f3 000 → ADD (b30=0) or SUB (b30=1)
    - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR
    - 101 → SRL (b30=0) or SRA (b30=1)
    - 110 → OR; 111 → AND
  - OP-IMM 0010011, src1=rs1, src2=imm:
    - 000 → ADD; 010 → SLT; 011 → SLTU; 100 → XOR; 110 → OR; 111 → AND
    - 001 → SLLI
    - 101 → SRLI (b30=0) or SRAI (b30=1)
  - OP-32 0111011, src2=rs2:
    - 000 → ADDW/SUBW by b30
    - 001 → SLLW
    - 101 → SRLW/SRAW by b30
    - other f3 → illegal
  - OP-IMM-32 0011011, src2=imm:
    - 000 → ADDIW
    - 001 → SLLW
    - 101 → SRLW/SRAW by b30
    - other f3 → illegal
  - LOAD 0000011, STORE 0100011, JALR 1100111: ADD, rs1 + imm.
  - BRANCH 1100011, src2=rs2:
    - f3 000/001 → SUB
    - 100/101 → SLT
    - 110/111 → SLTU
    - 010/011 → illegal
  - LUI 0110111: ADD, src1=0, src2=imm.
  - AUIPC 0010111 and JAL 1101111: ADD, src1=pc, src2=imm.
  - Any other opcode: illegal.
- Illegal handling: alu_control=ADD, src1=rs1, src2=rs2, o_illegal_instr=1. The entry still flows through the handshake.
- ALU control codes:
  - ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLL 00101, SLT 00110, SLTU 00111
  - SRL 01000, SRA 01001, SLLI 01010, SRLI 01011, SRAI 01100
  - ADDW 01101, SUBW 01110, SLLW 01111, SRLW 10000, SRAW 10001, ADDIW 10010

Decomposition:
- Package alu_pkg holds:
  - enum t_alu_op with the codes above (shared with the ALU)
  - opcode constants (OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - struct t_issue_payload {alu_control, src_1, src_2, illegal}
- Sub-module alu_op_decoder: purely combinational decode of instruction, pc, rs1, rs2 and imm into t_issue_payload.
- The top level holds the 2-entry skid buffer.

Test Plan:
- Reset: assert arstn=0 mid-transfer → o_valid=0 and o_ready=1 immediately (async); outputs zero.
- Single op: instr 0x40B50533 (sub a0,a0,a1), rs1=10, rs2=3, i_ready=1 → next cycle o_valid=1, alu_control=00001, src_1=10, src_2=3.
- Immediate/PC: AUIPC with pc=0x1000, imm=0x2000 → ADD, src_1=0x1000, src_2=0x2000. srai (b30=1, f3=101, OP-IMM) → 01100.
- Backpressure: stream of 4 ops, i_ready held 0 for 3 cycles → o_ready drops after the 2nd accept, payload stable, no loss or duplication, in-order drain at 1 op/cycle once i_ready=1.
- Flush: both entries full, i_flush=1 with i_valid=1 → next cycle o_valid=0 and o_ready=1; the incoming op never appears.
- Illegal: OP-32 with f3=010 and BRANCH with f3=011 → o_illegal_instr=1, alu_control=00000, src_1=rs1, src_2=rs2, handshake completes normally.
